mod_mul_barrett: RTL
====================

MOD_MUL_BARRETT -- requirements
Module: mod_mul_barrett

Interface
REQ-001 SHALL take `DWIDTH from defines.vh, default 12: coefficient width.
REQ-002 SHALL take `KYBER_Q from defines.vh, default 3329: modulus.
REQ-003 SHALL take parameter TAG_W, default 8: width of the sideband tag (coefficient index).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1: operand pair offered.
REQ-007 SHALL have port in_ready, output, 1: operand pair accepted when in_valid && in_ready.
REQ-008 SHALL have port a, input, `DWIDTH: operand (coefficient), legal range 0..Q-1.
REQ-009 SHALL have port b, input, `DWIDTH: operand (twiddle zeta), legal range 0..Q-1.
REQ-010 SHALL have port in_tag, input, TAG_W: sideband, carried unchanged.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: downstream (mod_add/mod_sub butterfly) accepts.
REQ-013 SHALL have port out, output, `DWIDTH: (a*b) mod Q, in range 0..Q-1.
REQ-014 SHALL have port out_tag, output, TAG_W: in_tag of the same transaction.

Function
REQ-015 SHALL compute out = (a*b) mod Q exactly for all legal a, b; results SHALL be fed directly to a mod_add input with no further reduction.
REQ-016 SHALL be a 3-stage pipeline; stage 1 registers p = a*b (24 bits, max 3328^2 = 11075584).
REQ-017 SHALL register in stage 2 the quotient estimate t = (p*M) >> 24 with M = floor(2^24/Q) = 5039, plus p.
REQ-018 SHALL form in stage 3 r = p - t*Q (width >= 14 bits) and apply up to two conditional subtractions of Q so the registered out is < Q.
REQ-019 SHALL keep intermediates unsigned; no intermediate may truncate before final reduction.
REQ-020 SHALL have a latency of 3 cycles: a transfer accepted at edge N presents out_valid at edge N+3 when out_ready is held high.
REQ-021 SHALL sustain throughput of one transaction per cycle when out_ready is continuously high.
REQ-022 SHALL use a single pipeline advance enable, en = !out_valid || out_ready; all stages (data, tag, valid bit) SHALL advance only when en is high.
REQ-023 SHALL drive in_ready = en combinationally; in_ready SHALL NOT depend on in_valid.
REQ-024 SHALL hold out, out_tag and out_valid stable while out_valid && !out_ready (no drop, no duplicate).
REQ-025 SHALL propagate bubbles: a stage with valid=0 SHALL still advance when en is high, so bubbles collapse only at the output stage.
REQ-026 SHALL ignore a, b and in_tag when in_valid is low; only the stage-1 valid bit SHALL be loaded with 0.
REQ-027 SHALL allow simultaneous output consumption and input acceptance in one cycle with no loss.
REQ-028 SHALL leave behaviour for a >= Q or b >= Q unspecified, except that out_valid/handshake timing is unaffected.

Reset
REQ-029 SHALL clear all three stage valid bits on rst_n low, asynchronously, so out_valid = 0 immediately.
REQ-030 SHALL reset out and out_tag to 0; internal data registers MAY be left unreset.
REQ-031 SHALL discard in-flight transactions on reset mid-operation; after rst_n rises the first accepted pair SHALL appear after exactly 3 cycles.
REQ-032 SHALL present in_ready = 1 from reset release (pipeline empty).

Verification
REQ-033 SHALL be checked with a=3328, b=3328, tag=0x01 -> out=1, out_tag=0x01, 3 cycles later.
REQ-034 SHALL be checked with a=17, b=1729 -> out=2761; with a=0, b=2000 -> out=0; with a=1, b=3328 -> out=3328.
REQ-035 SHALL be checked with back-to-back stream of 8 pairs, out_ready=1 -> 8 consecutive out_valid cycles, results and tags in order, starting cycle 3.
REQ-036 SHALL be checked with out_ready=0 for 5 cycles while streaming -> in_ready falls once pipeline holds 3 items, out held stable, no loss/duplication after release.
REQ-037 SHALL be checked with rst_n pulsed low while 3 items are in flight -> out_valid=0 immediately, none of the 3 items emerge, next input returns in 3 cycles.
REQ-038 SHALL be checked with random legal a, b (>= 10000 pairs) and random out_ready -> every out equals (a*b) mod 3329 against a reference model.

Source files
------------

// File: rtl/mod_mul_barrett.sv
// Modular multiplier (a*b) mod Q using Barrett reduction, three-stage
// valid/ready pipeline with a sideband tag carried alongside each operand pair.
// Stage 1: product, stage 2: quotient estimate, stage 3: correction and output.

`ifndef DWIDTH
`define DWIDTH 12
`endif
`ifndef KYBER_Q
`define KYBER_Q 3329
`endif

module mod_mul_barrett #(
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [`DWIDTH-1:0] a,
    input  logic [`DWIDTH-1:0] b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [`DWIDTH-1:0] out,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int DW    = `DWIDTH;
    localparam int Q     = `KYBER_Q;
    localparam int P_W   = 2 * DW;               // full product width
    localparam int SHIFT = P_W;                  // Barrett shift k
    localparam int M     = (1 << SHIFT) / Q;     // floor(2^k / Q)
    localparam int M_W   = $clog2(M + 1);
    localparam int PM_W  = P_W + M_W;            // exact width of p*M
    localparam int T_W   = PM_W - SHIFT;         // quotient estimate width
    localparam int R_W   = DW + 2;               // holds a remainder below 3*Q

    localparam logic [PM_W-1:0] M_L = PM_W'(M);
    localparam logic [P_W-1:0]  Q_P = P_W'(Q);
    localparam logic [R_W-1:0]  Q_R = R_W'(Q);

    // Single advance enable: the whole pipe moves unless the output is stalled.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage registers
    logic             v1, v2;
    logic [P_W-1:0]   p1, p2;
    logic [T_W-1:0]   t2;
    logic [TAG_W-1:0] tag1, tag2;

    // Combinational datapath between stages
    logic [T_W-1:0] t_next;
    logic [P_W-1:0] tq;
    logic [R_W-1:0] r0, r1;
    logic [DW-1:0]  out_next;

    // Quotient estimate from stage 1; remainder and two corrections from stage 2.
    // NOTE: always_comb uses blocking '=' so each line sees the previous result;
    // every variable is assigned on every path so no latch can be inferred.
    always_comb begin
        t_next   = T_W'((PM_W'(p1) * M_L) >> SHIFT);
        tq       = P_W'(t2) * Q_P;
        // t never exceeds floor(p/Q), so p - t*Q is non-negative and below 3*Q.
        r0       = R_W'(p2 - tq);
        r1       = (r0 >= Q_R) ? (r0 - Q_R) : r0;
        out_next = DW'((r1 >= Q_R) ? (r1 - Q_R) : r1);
    end

    // Valid bits and the output register: cleared asynchronously so the
    // pipe looks empty the moment reset asserts.
    // NOTE: state updates use non-blocking '<=' so all stages sample the
    // pre-edge values and shift together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            out_tag   <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            out       <= out_next;
            out_tag   <= tag2;
        end
    end

    // Internal data registers advance with the valid bits; bubbles carry
    // whatever data happens to be on the inputs, which is never observed.
    // NOTE: these are deliberately left without reset: their contents only
    // matter when the matching valid bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        if (en) begin
            p1   <= P_W'(a) * P_W'(b);
            tag1 <= in_tag;
            p2   <= p1;
            t2   <= t_next;
            tag2 <= tag1;
        end
    end

endmodule
